// File: rtl/dff_usr_bank.sv
// WIDTH-bit register bank with clock enable, synchronous reset to RST_VAL and a
// mode select for hold, shift, rotate, parallel load, clear and invert.
module dff_usr_bank #(
  parameter int unsigned           WIDTH   = 8,
  parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] data,
  input  logic             sin_r,
  input  logic             sin_l,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QB,
  output logic             sout_r,
  output logic             sout_l,
  output logic             zero
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_ROR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_LOAD = 3'b101;
  localparam logic [2:0] MODE_CLR  = 3'b110;
  localparam logic [2:0] MODE_INV  = 3'b111;

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next-state selection; en=0 or hold mode keeps the current contents.
  always_comb begin
    q_d = q_q;
    if (en) begin
      case (mode)
        MODE_HOLD: q_d = q_q;
        MODE_SHR:  q_d = {sin_r, q_q[WIDTH-1:1]};
        MODE_SHL:  q_d = {q_q[WIDTH-2:0], sin_l};
        MODE_ROR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
        MODE_ROL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        MODE_LOAD: q_d = data;
        MODE_CLR:  q_d = '0;
        MODE_INV:  q_d = ~q_q;
        default:   q_d = q_q;
      endcase
    end
  end

  // Reset wins over enable and mode, discarding any operation that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  // Status outputs are pure decodes of the stored value.
  assign Q      = q_q;
  assign QB     = ~q_q;
  assign sout_r = q_q[0];
  assign sout_l = q_q[WIDTH-1];
  assign zero   = (q_q == '0);

endmodule

// File: tb/tb_dff_usr_bank.sv
// Bench for dff_usr_bank: directed scenarios plus randomized traffic, checked
// against an arithmetic reference model on three widths (8, 2 and 32).
module tb_dff_usr_bank;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, sin_r, sin_l;
  logic [2:0]  mode;
  logic [31:0] data;

  logic [7:0]  q8, qb8;
  logic        sr8, sl8, z8;
  logic [1:0]  q2, qb2;
  logic        sr2, sl2, z2;
  logic [31:0] q32, qb32;
  logic        sr32, sl32, z32;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m8, m2, m32;

  dff_usr_bank #(.WIDTH(8), .RST_VAL(8'hA5)) u_w8 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .data(data[7:0]),
    .sin_r(sin_r), .sin_l(sin_l), .Q(q8), .QB(qb8),
    .sout_r(sr8), .sout_l(sl8), .zero(z8)
  );

  dff_usr_bank #(.WIDTH(2), .RST_VAL(2'b00)) u_w2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .data(data[1:0]),
    .sin_r(sin_r), .sin_l(sin_l), .Q(q2), .QB(qb2),
    .sout_r(sr2), .sout_l(sl2), .zero(z2)
  );

  dff_usr_bank #(.WIDTH(32), .RST_VAL(32'h0)) u_w32 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .data(data),
    .sin_r(sin_r), .sin_l(sin_l), .Q(q32), .QB(qb32),
    .sout_r(sr32), .sout_l(sl32), .zero(z32)
  );

  function automatic logic [31:0] width_mask(input int unsigned w);
    if (w >= 32) return 32'hFFFF_FFFF;
    return (32'd1 << w) - 32'd1;
  endfunction

  // Reference: the register viewed as an unsigned number of w bits.
  function automatic logic [31:0] ref_next(input logic [31:0] q, input int unsigned w,
                                           input logic [31:0] rv, input logic r, input logic e,
                                           input logic [2:0] md, input logic [31:0] d,
                                           input logic sr, input logic sl);
    logic [31:0] mask;
    mask = width_mask(w);
    if (r) return rv & mask;
    if (!e) return q;
    case (md)
      3'd1:    return (q >> 1) | (32'(sr) << (w - 1));
      3'd2:    return ((q << 1) | 32'(sl)) & mask;
      3'd3:    return (q >> 1) | ((q & 32'd1) << (w - 1));
      3'd4:    return ((q << 1) | (q >> (w - 1))) & mask;
      3'd5:    return d & mask;
      3'd6:    return 32'd0;
      3'd7:    return ~q & mask;
      default: return q;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input string tag, input logic [31:0] q, input logic [31:0] qb,
                           input logic sr, input logic sl, input logic z,
                           input logic [31:0] m, input int unsigned w);
    chk({tag, ".Q"}, q, m);
    chk({tag, ".QB"}, qb, ~m & width_mask(w));
    chk({tag, ".sout_r"}, 32'(sr), 32'(m[0]));
    chk({tag, ".sout_l"}, 32'(sl), 32'(m[w-1]));
    chk({tag, ".zero"}, 32'(z), 32'(m == 32'd0));
  endtask

  task automatic check_all();
    check_dut("w8", 32'(q8), 32'(qb8), sr8, sl8, z8, m8, 8);
    check_dut("w2", 32'(q2), 32'(qb2), sr2, sl2, z2, m2, 2);
    check_dut("w32", q32, qb32, sr32, sl32, z32, m32, 32);
  endtask

  // One clock: drive inputs, advance the models at the edge, sample 1 ns later.
  task automatic step(input logic r, input logic e, input logic [2:0] md,
                      input logic [31:0] d, input logic sr, input logic sl);
    rst = r; en = e; mode = md; data = d; sin_r = sr; sin_l = sl;
    @(posedge clk);
    m8  = ref_next(m8, 8, 32'hA5, r, e, md, d, sr, sl);
    m2  = ref_next(m2, 2, 32'h0, r, e, md, d, sr, sl);
    m32 = ref_next(m32, 32, 32'h0, r, e, md, d, sr, sl);
    #1;
    check_all();
  endtask

  logic [31:0] saved;
  logic [31:0] hist;
  logic        b;

  initial begin
    rst = 1'b1; en = 1'b1; mode = 3'b101; data = 32'hFF; sin_r = 1'b0; sin_l = 1'b0;
    m8 = 'x; m2 = 'x; m32 = 'x;

    // Reset beats a pending load.
    step(1'b1, 1'b1, 3'b101, 32'hFF, 1'b0, 1'b0);
    chk("rst.Q", 32'(q8), 32'hA5);
    chk("rst.QB", 32'(qb8), 32'h5A);
    step(1'b1, 1'b1, 3'b101, 32'hFF, 1'b0, 1'b0);
    chk("rst2.Q", 32'(q8), 32'hA5);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 3'b111, 32'h0, 1'b1, 1'b1);
      chk("hold_en0.Q", 32'(q8), 32'hA5);
    end

    // Load, clear and zero flag.
    step(1'b0, 1'b1, 3'b101, 32'h3C, 1'b0, 1'b0);
    chk("load.Q", 32'(q8), 32'h3C);
    chk("load.zero", 32'(z8), 32'h0);
    step(1'b0, 1'b1, 3'b110, 32'h3C, 1'b1, 1'b1);
    chk("clr.Q", 32'(q8), 32'h00);
    chk("clr.zero", 32'(z8), 32'h1);
    chk("clr.QB", 32'(qb8), 32'hFF);

    // Serial shifts.
    step(1'b0, 1'b1, 3'b101, 32'h81, 1'b0, 1'b0);
    step(1'b0, 1'b1, 3'b001, 32'h0, 1'b1, 1'b1);
    chk("shr.Q", 32'(q8), 32'hC0);
    chk("shr.sout_r", 32'(sr8), 32'h0);
    step(1'b0, 1'b1, 3'b010, 32'h0, 1'b1, 1'b0);
    chk("shl1.Q", 32'(q8), 32'h80);
    step(1'b0, 1'b1, 3'b010, 32'h0, 1'b1, 1'b0);
    chk("shl2.Q", 32'(q8), 32'h00);

    // Rotate wrap-around.
    step(1'b0, 1'b1, 3'b101, 32'h96, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b1, 3'b011, 32'h0, 1'b1, 1'b1);
      if (i == 1) chk("ror1.Q", 32'(q8), 32'h4B);
    end
    chk("ror8.Q", 32'(q8), 32'h96);
    step(1'b0, 1'b1, 3'b100, 32'h0, 1'b1, 1'b1);
    chk("rol.Q", 32'(q8), 32'h2D);

    // Invert twice, then a shift with no bubble.
    step(1'b0, 1'b1, 3'b101, 32'hF0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 3'b111, 32'h0, 1'b1, 1'b1);
    chk("inv1.Q", 32'(q8), 32'h0F);
    step(1'b0, 1'b1, 3'b111, 32'h0, 1'b1, 1'b1);
    chk("inv2.Q", 32'(q8), 32'hF0);
    step(1'b0, 1'b1, 3'b001, 32'h0, 1'b0, 1'b1);
    chk("inv_shr.Q", 32'(q8), 32'h78);

    // Reset in the middle of a rotate sequence.
    step(1'b0, 1'b1, 3'b101, 32'h96, 1'b0, 1'b0);
    step(1'b0, 1'b1, 3'b011, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 3'b011, 32'h0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 3'b011, 32'h0, 1'b0, 1'b0);
    chk("midrst.Q", 32'(q8), 32'hA5);
    step(1'b0, 1'b1, 3'b011, 32'h0, 1'b0, 1'b0);
    chk("midrst_ror.Q", 32'(q8), 32'hD2);

    // WIDTH=2 rotate wrap.
    step(1'b0, 1'b1, 3'b101, 32'h1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 3'b100, 32'h0, 1'b0, 1'b0);
    chk("w2_rol1.Q", 32'(q2), 32'h2);
    step(1'b0, 1'b1, 3'b100, 32'h0, 1'b0, 1'b0);
    chk("w2_rol2.Q", 32'(q2), 32'h1);

    // WIDTH=32: full rotate returns, full shift holds the serial history.
    saved = $urandom;
    step(1'b0, 1'b1, 3'b101, saved, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 3'b011, $urandom, 1'b1, 1'b1);
    chk("w32_ror32.Q", q32, saved);
    hist = 32'h0;
    for (int k = 0; k < 32; k++) begin
      b = 1'($urandom);
      hist[k] = b;
      step(1'b0, 1'b1, 3'b001, $urandom, b, ~b);
    end
    chk("w32_shr_hist.Q", q32, hist);
    hist = 32'h0;
    for (int k = 0; k < 8; k++) begin
      b = 1'($urandom);
      hist[7-k] = b;
      step(1'b0, 1'b1, 3'b010, $urandom, ~b, b);
    end
    chk("w8_shl_hist.Q", 32'(q8), hist);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
           3'($urandom_range(0, 7)), $urandom, 1'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
